// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared key FSM states, parameter defaults and counter sizing for input_conditioner.
package input_cond_pkg;
`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD_DELAY, REPEAT} key_state_t;
`else
  typedef enum logic {IDLE, HELD} key_state_t;
`endif
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_PERIOD = 12500000;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/input_conditioner_sync_debounce.sv
// sync_debounce: flop-chain synchroniser followed by a stable-count debouncer for one raw input.
module sync_debounce
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  // The counter only runs while the synced level disagrees, so it clears before it could wrap.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync  <= {SYNC_STAGES{RESET_VAL}};
      level <= RESET_VAL;
      cnt   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (sync[SYNC_STAGES-1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced W level and one-cycle Step strobe per key press.
// Define AUTO_REPEAT_EN to add hold-to-repeat Step pulses.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyN,
  input  logic SwW,
  output logic WOut,
  output logic KeyHeld,
  output logic Step
);
  key_state_t state, state_next;
  logic step_next;
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_sw (
    .Clock(Clock), .Reset(Reset), .raw(SwW), .level(WOut)
  );
  // Inverting before the chain makes the key chain's reset value of 0 mean "not pressed".
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_key (
    .Clock(Clock), .Reset(Reset), .raw(~KeyN), .level(KeyHeld)
  );
`ifdef AUTO_REPEAT_EN
  localparam int TW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic [TW-1:0] timer, timer_next;
  always_comb begin
    state_next = state;
    step_next  = 1'b0;
    timer_next = '0;
    case (state)
      IDLE: begin
        state_next = KeyHeld ? HOLD_DELAY : IDLE;
        step_next  = KeyHeld;
      end
      HOLD_DELAY: begin
        state_next = !KeyHeld ? IDLE : timer == TW'(REPEAT_DELAY - 1) ? REPEAT : HOLD_DELAY;
        step_next  = KeyHeld && timer == TW'(REPEAT_DELAY - 1);
        timer_next = (state_next == HOLD_DELAY) ? timer + TW'(1) : '0;
      end
      default: begin
        state_next = KeyHeld ? REPEAT : IDLE;
        step_next  = KeyHeld && timer == TW'(REPEAT_PERIOD - 1);
        timer_next = (KeyHeld && !step_next) ? timer + TW'(1) : '0;
      end
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Step  <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_next;
      Step  <= step_next;
      timer <= timer_next;
    end
  end
`else
  always_comb begin
    state_next = KeyHeld ? HELD : IDLE;
    step_next  = (state == IDLE) && KeyHeld;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Step  <= 1'b0;
    end else begin
      state <= state_next;
      Step  <= step_next;
    end
  end
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scoreboard bench; expectations are queued by cycle and checked by a monitor.
module tb_input_conditioner;
  logic clk = 1'b0, rst = 1'b1, key_n = 1'b0, sw_w = 1'b1;
  logic w_out, key_held, step;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int at; int sig; bit val;} lvl_t;
  lvl_t lvl_q[$];
  int step_q[$];
  string names[3] = '{"wout", "keyheld", "step"};

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
    .Clock(clk), .Reset(rst), .KeyN(key_n), .SwW(sw_w), .WOut(w_out), .KeyHeld(key_held), .Step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_lvl(int at, int sig, bit val);
    lvl_q.push_back('{at, sig, val});
  endfunction

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = lvl_q.size() - 1; i >= 0; i--) begin
      if (lvl_q[i].at == cyc) begin
        logic a;
        a = lvl_q[i].sig == 0 ? w_out : lvl_q[i].sig == 1 ? key_held : step;
        checks++;
        if (a !== lvl_q[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b", names[lvl_q[i].sig], cyc, a, lvl_q[i].val);
        end
        lvl_q.delete(i);
      end
    end
    while (step_q.size() > 0 && step_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL step_missing cyc %0d got none want pulse at %0d", cyc, step_q[0]);
      void'(step_q.pop_front());
    end
    if (step === 1'b1) begin
      checks++;
      if (step_q.size() == 0 || step_q[0] != cyc) begin
        errors++;
        $display("FAIL step_unexpected got pulse at %0d want next at %0d", cyc, step_q.size() ? step_q[0] : -1);
      end else void'(step_q.pop_front());
    end
  end

  initial begin
    // 1: reset with key pressed and switch high
    for (int c = 1; c <= 3; c++) begin
      exp_lvl(c, 0, 0); exp_lvl(c, 1, 0); exp_lvl(c, 2, 0);
    end
    exp_lvl(8, 0, 0); exp_lvl(9, 0, 1); exp_lvl(8, 1, 0); exp_lvl(9, 1, 1);
    step_q.push_back(10); exp_lvl(11, 2, 0);
    at(3); rst = 1'b0;
    exp_lvl(17, 1, 1); exp_lvl(18, 1, 0); exp_lvl(17, 0, 1); exp_lvl(18, 0, 0);
    at(12); key_n = 1'b1; sw_w = 1'b0;
    // 2: switch glitch of 3 cycles
    for (int c = 26; c <= 36; c++) exp_lvl(c, 0, 0);
    at(25); sw_w = 1'b1;
    at(28); sw_w = 1'b0;
    // 3: 20-cycle press
    exp_lvl(45, 1, 0); exp_lvl(46, 1, 1); step_q.push_back(47); exp_lvl(48, 2, 0);
`ifdef AUTO_REPEAT_EN
    step_q.push_back(57); step_q.push_back(62);
`endif
    exp_lvl(65, 1, 1); exp_lvl(66, 1, 0);
    at(40); key_n = 1'b0;
    at(60); key_n = 1'b1;
    // 4: bouncing key then steady press
    exp_lvl(90, 1, 0); exp_lvl(91, 1, 1); step_q.push_back(92);
`ifdef AUTO_REPEAT_EN
    step_q.push_back(102);
`endif
    exp_lvl(106, 1, 0);
    for (int i = 0; i < 10; i++) begin
      at(75 + i); key_n = (i % 2) != 0;
    end
    at(85); key_n = 1'b0;
    at(100); key_n = 1'b1;
    // 5: 40-cycle hold
    step_q.push_back(122);
`ifdef AUTO_REPEAT_EN
    step_q.push_back(132); step_q.push_back(137); step_q.push_back(142);
    step_q.push_back(147); step_q.push_back(152); step_q.push_back(157);
`endif
    exp_lvl(123, 2, 0); exp_lvl(161, 1, 0); exp_lvl(162, 2, 0); exp_lvl(163, 2, 0);
    at(115); key_n = 1'b0;
    at(155); key_n = 1'b1;
    // 6: reset during a hold, key kept pressed
    step_q.push_back(177);
`ifdef AUTO_REPEAT_EN
    step_q.push_back(187); step_q.push_back(192);
`endif
    exp_lvl(196, 2, 0); exp_lvl(196, 1, 0); exp_lvl(197, 2, 0); exp_lvl(198, 2, 0);
    step_q.push_back(204); exp_lvl(205, 2, 0); exp_lvl(211, 1, 0);
    at(170); key_n = 1'b0;
    at(195); rst = 1'b1;
    at(197); rst = 1'b0;
    at(205); key_n = 1'b1;
    at(220);
    @(posedge clk);
    checks++;
    if (step_q.size() != 0 || lvl_q.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d steps %0d levels left want 0", step_q.size(), lvl_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
